axi_lite_reg_bank: RTL



---
 rtl/axi_lite_reg_bank_pkg.sv | 35 +++
 rtl/axi_lite_reg_bank_if.sv | 29 ++
 rtl/axi_lite_reg_bank_timer.sv | 52 +++++
 rtl/axi_lite_reg_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/axi_lite_reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_reg_pkg : shared offsets, bit indices, FSM states, AXI responses    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package axi_lite_reg_pkg;

  localparam logic [7:0] REG_CONTROL = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h04;
  localparam logic [7:0] REG_SCRATCH = 8'h08;
  localparam logic [7:0] REG_COUNTER = 8'h0C;
  localparam logic [7:0] REG_COMPARE = 8'h10;
  localparam logic [7:0] REG_VERSION = 8'h14;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_CLR_BIT     = 2;
  localparam int STATUS_MATCH_BIT = 0;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_ACK  = 3'd3,
    ST_RD_ACK  = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_reg_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_reg_bank_if : user-side register request/strobe bus                 |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface axi_lite_reg_bank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_reg_in_rdy;
  logic                  o_reg_in_ack_stb;
  logic [ADDR_WIDTH-1:0] i_reg_address;
  logic [DATA_WIDTH-1:0] i_reg_in_data;
  logic                  i_reg_out_req;
  logic                  o_reg_out_rdy_stb;
  logic [DATA_WIDTH-1:0] o_reg_out_data;
  logic                  o_reg_invalid_addr;

  modport master (
    output i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    input  o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr
  );

  modport slave (
    input  i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    output o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_reg_bank_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_reg_timer : free-running counter with compare match / pending flag  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module axi_lite_reg_timer
  import axi_lite_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  w1c,
  input  logic [DATA_WIDTH-1:0] compare,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  pend
);

  logic [DATA_WIDTH-1:0] r_count;
  logic                  r_pend;
  logic                  w_match;

  assign w_match = en && (r_count == compare);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + DATA_WIDTH'(1);
    end
  end

  // A match on the same edge as a software clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else if (w_match) begin
      r_pend <= 1'b1;
    end else if (w1c) begin
      r_pend <= 1'b0;
    end
  end

  assign count = r_count;
  assign pend  = r_pend;

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_reg_bank : register bank behind the AXI-Lite slave user interface   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module axi_lite_reg_bank
  import axi_lite_reg_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] VERSION_ID  = 32'h0001_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_lite_reg_bank_if.slave  bus,
  output logic                o_irq
);

  state_e                r_state;
  state_e                w_next_state;
  logic [3:0]            r_wait_cnt;
  logic                  w_wait_done;
  logic                  w_commit_wr;
  logic                  w_commit_rd;

  logic                  r_en;
  logic                  r_irq_en;
  logic [DATA_WIDTH-1:0] r_scratch;
  logic [DATA_WIDTH-1:0] r_compare;
  logic [DATA_WIDTH-1:0] w_count;
  logic                  w_pend;

  logic                  r_ack_stb;
  logic                  r_rdy_stb;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_invalid;
  logic                  r_irq;

  logic [7:0]            w_word;
  logic                  w_upper_zero;
  logic                  w_hit;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;

  // Low two address bits are byte lanes and do not take part in the decode
  assign w_word       = 8'(bus.i_reg_address) & 8'hFC;
  assign w_upper_zero = (bus.i_reg_address >> 8) == '0;
  assign w_valid      = w_hit && w_upper_zero;

  always_comb begin
    w_hit     = 1'b0;
    w_rd_data = '0;
    case (w_word)
      REG_CONTROL: begin
        w_hit                      = 1'b1;
        w_rd_data[CTRL_EN_BIT]     = r_en;
        w_rd_data[CTRL_IRQ_EN_BIT] = r_irq_en;
      end
      REG_STATUS: begin
        w_hit                       = 1'b1;
        w_rd_data[STATUS_MATCH_BIT] = w_pend;
      end
      REG_SCRATCH: begin w_hit = 1'b1; w_rd_data = r_scratch;               end
      REG_COUNTER: begin w_hit = 1'b1; w_rd_data = w_count;                 end
      REG_COMPARE: begin w_hit = 1'b1; w_rd_data = r_compare;               end
      REG_VERSION: begin w_hit = 1'b1; w_rd_data = DATA_WIDTH'(VERSION_ID); end
      default: ;
    endcase
  end

  assign w_wait_done = (r_wait_cnt == 4'd0);
  assign w_commit_wr = (r_state == ST_WR_WAIT) && w_wait_done;
  assign w_commit_rd = (r_state == ST_RD_WAIT) && w_wait_done;
  assign w_wr_ctrl   = w_commit_wr && w_valid && (w_word == REG_CONTROL);
  assign w_wr_status = w_commit_wr && w_valid && (w_word == REG_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_reg_in_rdy) begin
          w_next_state = ST_WR_WAIT;
        end else if (bus.i_reg_out_req) begin
          w_next_state = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: if (w_wait_done) w_next_state = ST_WR_ACK;
      ST_RD_WAIT: if (w_wait_done) w_next_state = ST_RD_ACK;
      ST_WR_ACK:  w_next_state = ST_HOLD;
      ST_RD_ACK:  w_next_state = ST_HOLD;
      // Stay here until the requester lets go, so a held request is not re-served
      ST_HOLD: if (!bus.i_reg_in_rdy && !bus.i_reg_out_req) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == ST_IDLE) begin
      r_wait_cnt <= 4'(WAIT_CYCLES);
    end else if (!w_wait_done) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_scratch <= '0;
      r_compare <= '0;
    end else if (w_commit_wr && w_valid) begin
      case (w_word)
        REG_CONTROL: begin
          r_en     <= bus.i_reg_in_data[CTRL_EN_BIT];
          r_irq_en <= bus.i_reg_in_data[CTRL_IRQ_EN_BIT];
        end
        REG_SCRATCH: r_scratch <= bus.i_reg_in_data;
        REG_COMPARE: r_compare <= bus.i_reg_in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_stb <= 1'b0;
      r_rdy_stb <= 1'b0;
      r_rd_data <= '0;
      r_invalid <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ack_stb <= w_commit_wr;
      r_rdy_stb <= w_commit_rd;
      r_irq     <= w_pend && r_irq_en;
      if (w_commit_rd) begin
        r_rd_data <= w_valid ? w_rd_data : '0;
      end
      if ((r_state == ST_IDLE) && (bus.i_reg_in_rdy || bus.i_reg_out_req)) begin
        r_invalid <= 1'b0;
      end else if (w_commit_wr || w_commit_rd) begin
        r_invalid <= !w_valid;
      end
    end
  end

  axi_lite_reg_timer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (r_en),
    .clr     (w_wr_ctrl && bus.i_reg_in_data[CTRL_CLR_BIT]),
    .w1c     (w_wr_status && bus.i_reg_in_data[STATUS_MATCH_BIT]),
    .compare (r_compare),
    .count   (w_count),
    .pend    (w_pend)
  );

  assign bus.o_reg_in_ack_stb   = r_ack_stb;
  assign bus.o_reg_out_rdy_stb  = r_rdy_stb;
  assign bus.o_reg_out_data     = r_rd_data;
  assign bus.o_reg_invalid_addr = r_invalid;
  assign o_irq                  = r_irq;

endmodule
`default_nettype wire
